rs_decode_ctrl: RTL and testbench

Sequencing controller for the RS(7,3) single-error decoder over GF(8). Accepts one 21-bit codeword per valid/ready handshake, folds it serially into syndromes S1 and S2, then time-shares one general GF(8) multiplier to solve for the error locator X1 and magnitude Y1. It corrects the codeword and presents the 9-bit message with status on an output valid/ready port.

---
 rtl/rs_gf8_pkg.sv | 22 ++
 rtl/gf8_mul.sv | 22 ++
 rtl/rs_decode_ctrl.sv | 128 ++++++++++++
 tb/tb_rs_decode_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rs_gf8_pkg.sv
// GF(8) field constants, lookup tables and controller state encoding for the
// RS(7,3) single-error decoder.
package rs_gf8_pkg;
    localparam int SYM_W = 3;
    localparam int N     = 7;
    localparam int K     = 3;
    localparam int CW_W  = N * SYM_W;
    localparam int MSG_W = K * SYM_W;

    localparam logic [SYM_W:0]   PRIM_POLY = 4'b1011;
    localparam logic [SYM_W-1:0] ALPHA     = 3'b010;
    localparam logic [SYM_W-1:0] ALPHA2    = 3'b100;

    // Tables are packed with index 7 leftmost; log(0) and inv(0) are 0 by definition.
    localparam logic [7:0][SYM_W-1:0] LOG_TBL  = {3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0};
    localparam logic [7:0][SYM_W-1:0] ALOG_TBL = {3'd1, 3'd5, 3'd7, 3'd6, 3'd3, 3'd4, 3'd2, 3'd1};
    localparam logic [7:0][SYM_W-1:0] INV_TBL  = {3'd4, 3'd3, 3'd2, 3'd7, 3'd6, 3'd5, 3'd1, 3'd0};

    typedef enum logic [2:0] {
        IDLE, SYND, SOLVE0, SOLVE1, SOLVE2, CORR, DONE
    } state_t;
endpackage

// File: rtl/gf8_mul.sv
// Combinational GF(8) multiplier: carry-less product reduced by the primitive polynomial.
module gf8_mul
    import rs_gf8_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic [SYM_W-1:0] p
);
    logic [2*SYM_W-2:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) prod = prod ^ ((2*SYM_W-1)'(a) << i);
        end
        // Fold x^4 then x^3 back into the field.
        for (int k = 2*SYM_W-2; k >= SYM_W; k--) begin
            if (prod[k]) prod = prod ^ ((2*SYM_W-1)'(PRIM_POLY) << (k - SYM_W));
        end
        p = prod[SYM_W-1:0];
    end
endmodule

// File: rtl/rs_decode_ctrl.sv
// RS(7,3) single-error decode sequencer: serial syndromes, one shared GF(8)
// multiplier for the locator/magnitude solve, then a registered correction.
module rs_decode_ctrl
    import rs_gf8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MSG_W-1:0]  out_decoded,
    output logic [CW_W-1:0]   out_corrected,
    output logic [SYM_W-1:0]  out_err_pos,
    output logic              out_corrected_flag,
    output logic              out_uncorrectable
);
    state_t           state;
    logic [CW_W-1:0]  cw;
    logic [SYM_W-1:0] s1, s2, m, x1, y1;
    logic [2:0]       cnt;

    logic [SYM_W-1:0] sym, s1_alpha, s2_alpha2;
    logic [SYM_W-1:0] mul_a, mul_b, mul_p;
    logic [SYM_W-1:0] pos;
    logic [CW_W-1:0]  err_vec;

    assign sym = cw[SYM_W*int'(cnt) +: SYM_W];

    // Constant multiplies by alpha and alpha^2, reduced with x^3 = x + 1.
    assign s1_alpha  = {s1[1], s1[0] ^ s1[2], s1[2]};
    assign s2_alpha2 = {s2[2] ^ s2[0], s2[2] ^ s2[1], s2[1]};

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SOLVE0: begin mul_a = s1; mul_b = s1;           end
            SOLVE1: begin mul_a = s2; mul_b = INV_TBL[s1];  end
            SOLVE2: begin mul_a = m;  mul_b = INV_TBL[s2];  end
            default: ;
        endcase
    end

    gf8_mul u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

    assign pos     = LOG_TBL[x1];
    assign err_vec = {{(CW_W-SYM_W){1'b0}}, y1} << (SYM_W * int'(pos));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            in_ready           <= 1'b0;
            out_valid          <= 1'b0;
            cw                 <= '0;
            s1                 <= '0;
            s2                 <= '0;
            m                  <= '0;
            x1                 <= '0;
            y1                 <= '0;
            cnt                <= '0;
            out_decoded        <= '0;
            out_corrected      <= '0;
            out_err_pos        <= '0;
            out_corrected_flag <= 1'b0;
            out_uncorrectable  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cw       <= in_codeword;
                        s1       <= '0;
                        s2       <= '0;
                        cnt      <= 3'(N-1);
                        in_ready <= 1'b0;
                        state    <= SYND;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SYND: begin
                    s1  <= s1_alpha ^ sym;
                    s2  <= s2_alpha2 ^ sym;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) state <= SOLVE0;
                end
                SOLVE0: begin m  <= mul_p; state <= SOLVE1; end
                SOLVE1: begin x1 <= mul_p; state <= SOLVE2; end
                SOLVE2: begin y1 <= mul_p; state <= CORR;   end
                CORR: begin
                    out_valid <= 1'b1;
                    state     <= DONE;
                    if ((s1 == '0) && (s2 == '0)) begin
                        out_corrected      <= cw;
                        out_decoded        <= cw[CW_W-1 -: MSG_W];
                        out_err_pos        <= '0;
                        out_corrected_flag <= 1'b0;
                        out_uncorrectable  <= 1'b0;
                    end else if ((s1 == '0) || (s2 == '0)) begin
                        out_corrected      <= cw;
                        out_decoded        <= cw[CW_W-1 -: MSG_W];
                        out_err_pos        <= '0;
                        out_corrected_flag <= 1'b0;
                        out_uncorrectable  <= 1'b1;
                    end else begin
                        out_corrected      <= cw ^ err_vec;
                        out_decoded        <= cw[CW_W-1 -: MSG_W] ^ err_vec[CW_W-1 -: MSG_W];
                        out_err_pos        <= pos;
                        out_corrected_flag <= 1'b1;
                        out_uncorrectable  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rs_decode_ctrl.sv
// Self-checking bench for rs_decode_ctrl: directed vectors, randomized
// codewords with 0/1/2 symbol errors, backpressure and mid-decode reset.
module tb_rs_decode_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_codeword;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_decoded;
    logic [20:0] out_corrected;
    logic [2:0]  out_err_pos;
    logic        out_corrected_flag;
    logic        out_uncorrectable;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_t [7];
    int log_t [8];

    always #5 clk = ~clk;

    rs_decode_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_codeword        (in_codeword),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_decoded        (out_decoded),
        .out_corrected      (out_corrected),
        .out_err_pos        (out_err_pos),
        .out_corrected_flag (out_corrected_flag),
        .out_uncorrectable  (out_uncorrectable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 7];
    endfunction

    function automatic int gdiv(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] - log_t[b] + 7) % 7];
    endfunction

    function automatic int sym_of(input logic [20:0] cw, input int i);
        return int'((cw >> (3*i)) & 21'h7);
    endfunction

    // Reference decode: evaluate c(alpha), c(alpha^2) directly, then apply the decision rules.
    task automatic model(input logic [20:0] cw, output logic [20:0] corr,
                         output int pos, output int flag, output int unc);
        int s1 = 0, s2 = 0, x, y;
        for (int i = 0; i < 7; i++) begin
            s1 ^= gmul(sym_of(cw, i), exp_t[i % 7]);
            s2 ^= gmul(sym_of(cw, i), exp_t[(2*i) % 7]);
        end
        corr = cw; pos = 0; flag = 0; unc = 0;
        if (s1 == 0 && s2 == 0) begin
        end else if (s1 == 0 || s2 == 0) begin
            unc = 1;
        end else begin
            x = gdiv(s2, s1);
            y = gdiv(gmul(s1, s1), s2);
            pos = log_t[x];
            flag = 1;
            corr = cw ^ (21'(y) << (3*pos));
        end
    endtask

    // Systematic-free encoder: pick c2..c6, solve c0,c1 so both syndromes vanish.
    function automatic logic [20:0] make_codeword(input logic [14:0] hi);
        int r1 = 0, r2 = 0, c1, c0;
        logic [20:0] cw;
        cw = {hi, 6'd0};
        for (int i = 2; i < 7; i++) begin
            r1 ^= gmul(sym_of(cw, i), exp_t[i % 7]);
            r2 ^= gmul(sym_of(cw, i), exp_t[(2*i) % 7]);
        end
        c1 = gdiv(r1 ^ r2, 2 ^ 4);
        c0 = r1 ^ gmul(c1, 2);
        return {hi, 3'(c1), 3'(c0)};
    endfunction

    task automatic run_vec(input logic [20:0] cw, input int hold);
        logic [20:0] corr;
        int pos, flag, unc, lat, k;
        model(cw, corr, pos, flag, unc);
        k = 0;
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_codeword = cw;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_codeword = 21'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("latency", 32'(lat), 32'd11);
        check("corrected", 32'(out_corrected), 32'(corr));
        check("decoded", 32'(out_decoded), 32'(corr[20:12]));
        check("err_pos", 32'(out_err_pos), 32'(pos));
        check("corr_flag", 32'(out_corrected_flag), 32'(flag));
        check("uncorrectable", 32'(out_uncorrectable), 32'(unc));
        in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            in_codeword = 21'($urandom);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_corrected", 32'(out_corrected), 32'(corr));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [20:0] cw;
        int nerr, p1, p2, seen;
        exp_t[0] = 1;
        for (int i = 1; i < 7; i++) begin
            exp_t[i] = exp_t[i-1] * 2;
            if (exp_t[i] >= 8) exp_t[i] ^= 11;
        end
        log_t[0] = 0;
        for (int i = 0; i < 7; i++) log_t[exp_t[i]] = i;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_codeword = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_corrected", 32'(out_corrected), 32'd0);
        check("rst_decoded", 32'(out_decoded), 32'd0);
        check("rst_flags", {30'd0, out_corrected_flag, out_uncorrectable}, 32'd0);
        check("rst_err_pos", 32'(out_err_pos), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_vec(21'h001653, 0);
        check("dir_valid_decoded", 32'(out_decoded), 32'h001);
        run_vec(21'h001713, 0);
        check("dir_err2_pos", 32'(out_err_pos), 32'd2);
        run_vec(21'h018000, 0);
        check("dir_err5_pos", 32'(out_err_pos), 32'd5);
        run_vec(21'h00000C, 0);
        check("dir_unc_flag", 32'(out_uncorrectable), 32'd1);
        run_vec(21'h001653, 20);

        // Reset four edges into syndrome folding; that codeword must never complete.
        in_codeword = 21'h001713; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_corrected", 32'(out_corrected), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (15) begin @(posedge clk); #1; if (out_valid) seen = 1; end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_vec(21'h001653, 1);

        for (int t = 0; t < 40; t++) begin
            cw   = make_codeword(15'($urandom));
            nerr = $urandom_range(0, 2);
            p1   = $urandom_range(0, 6);
            p2   = (p1 + $urandom_range(1, 6)) % 7;
            if (nerr >= 1) cw ^= 21'($urandom_range(1, 7)) << (3*p1);
            if (nerr == 2) cw ^= 21'($urandom_range(1, 7)) << (3*p2);
            run_vec(cw, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
